// File: rtl/cr_unit_pkg.sv
// cr_unit_pkg: shared definitions for the Condition Register unit.
//   CR geometry (width, field width, in-field bit offsets), the CR-logical
//   opcode encoding and small helpers used by the merge logic.
//   Bit numbering is big-endian: architected bit 0 is the MSB of the vector.
package cr_unit_pkg;

  localparam int CR_WIDTH  = 32;
  localparam int CRF_WIDTH = 4;

  // bit offsets inside a 4-bit field, architected (big-endian) numbering
  localparam int CR_LT = 0;
  localparam int CR_GT = 1;
  localparam int CR_EQ = 2;
  localparam int CR_SO = 3;

  localparam int CRLOP_WIDTH = 3;

  typedef enum logic [CRLOP_WIDTH-1:0] {
    CRLOP_AND  = 3'd0,
    CRLOP_OR   = 3'd1,
    CRLOP_XOR  = 3'd2,
    CRLOP_NAND = 3'd3,
    CRLOP_NOR  = 3'd4,
    CRLOP_EQV  = 3'd5,
    CRLOP_ANDC = 3'd6,
    CRLOP_ORC  = 3'd7
  } crl_op_e;

  function automatic logic crl_eval(input crl_op_e op, input logic a, input logic b);
    logic r;
    case (op)
      CRLOP_AND:  r = a & b;
      CRLOP_OR:   r = a | b;
      CRLOP_XOR:  r = a ^ b;
      CRLOP_NAND: r = ~(a & b);
      CRLOP_NOR:  r = ~(a | b);
      CRLOP_EQV:  r = ~(a ^ b);
      CRLOP_ANDC: r = a & ~b;
      default:    r = a | ~b;
    endcase
    return r;
  endfunction

  // Pack {LT,GT,EQ} plus SO into a field, MSB of the nibble = architected bit 0.
  function automatic logic [CRF_WIDTH-1:0] make_field(input logic [2:0] d, input logic so);
    logic [CRF_WIDTH-1:0] f;
    f[CRF_WIDTH-1-CR_LT] = d[2];
    f[CRF_WIDTH-1-CR_GT] = d[1];
    f[CRF_WIDTH-1-CR_EQ] = d[0];
    f[CRF_WIDTH-1-CR_SO] = so;
    return f;
  endfunction

endpackage

// File: rtl/cr_unit_merge.sv
// cr_merge: combinational merge of the four CR write sources.
//   i_cr               current architected CR
//   i_alu_*            CR0 write from ALU record form
//   i_cmp_*            field write from compare ALU
//   i_xer_so           SO value copied into ALU/compare field writes
//   i_crl_*            single-bit CR-logical write (sources from i_cr)
//   i_mtcrf_*          masked field moves from a GPR
//   o_cr_next          post-merge CR, priority alu > cmp > crl > mtcrf
//   o_conflict         some bit was targeted by two or more sources
module cr_merge
  import cr_unit_pkg::*;
(
  input  logic [CR_WIDTH-1:0] i_cr,
  input  logic                i_alu_wr_en,
  input  logic [2:0]          i_alu_d,
  input  logic                i_cmp_wr_en,
  input  logic [2:0]          i_cmp_crf,
  input  logic [2:0]          i_cmp_d,
  input  logic                i_xer_so,
  input  logic                i_crl_en,
  input  logic [2:0]          i_crl_op,
  input  logic [4:0]          i_crl_bt,
  input  logic [4:0]          i_crl_ba,
  input  logic [4:0]          i_crl_bb,
  input  logic                i_mtcrf_en,
  input  logic [7:0]          i_mtcrf_fxm,
  input  logic [CR_WIDTH-1:0] i_mtcrf_data,
  output logic [CR_WIDTH-1:0] o_cr_next,
  output logic                o_conflict
);

  logic [CR_WIDTH-1:0] w_m_alu, w_m_cmp, w_m_crl, w_m_mt;
  logic [CR_WIDTH-1:0] w_v_alu, w_v_cmp, w_v_crl, w_v_mt;
  logic                w_crl_res;

  // Sources of a CR-logical op always come from the registered CR.
  assign w_crl_res = crl_eval(crl_op_e'(i_crl_op),
                              i_cr[5'd31 - i_crl_ba],
                              i_cr[5'd31 - i_crl_bb]);

  always_comb begin
    w_m_alu = '0;
    w_v_alu = '0;
    w_m_cmp = '0;
    w_v_cmp = '0;
    w_m_crl = '0;
    w_v_crl = '0;
    w_m_mt  = '0;
    w_v_mt  = '0;
    if (i_alu_wr_en) begin
      w_m_alu = {4'hF, 28'h0};
      w_v_alu = {make_field(i_alu_d, i_xer_so), 28'h0};
    end
    if (i_cmp_wr_en) begin
      w_m_cmp = {4'hF, 28'h0} >> {i_cmp_crf, 2'b00};
      w_v_cmp = {make_field(i_cmp_d, i_xer_so), 28'h0} >> {i_cmp_crf, 2'b00};
    end
    if (i_crl_en) begin
      w_m_crl = {1'b1, 31'h0} >> i_crl_bt;
      w_v_crl = {w_crl_res, 31'h0} >> i_crl_bt;
    end
    if (i_mtcrf_en) begin
      // fxm MSB selects field 0, matching the big-endian CR numbering
      for (int i = 0; i < 8; i++) begin
        if (i_mtcrf_fxm[7-i]) w_m_mt[31-4*i -: 4] = 4'hF;
      end
      w_v_mt = i_mtcrf_data & w_m_mt;
    end
  end

  always_comb begin
    o_cr_next = i_cr;
    // lowest priority first so higher-priority sources overwrite
    o_cr_next = (o_cr_next & ~w_m_mt)  | w_v_mt;
    o_cr_next = (o_cr_next & ~w_m_crl) | w_v_crl;
    o_cr_next = (o_cr_next & ~w_m_cmp) | w_v_cmp;
    o_cr_next = (o_cr_next & ~w_m_alu) | w_v_alu;
  end

  assign o_conflict = |((w_m_alu & w_m_cmp) | (w_m_alu & w_m_crl) | (w_m_alu & w_m_mt) |
                        (w_m_cmp & w_m_crl) | (w_m_cmp & w_m_mt)  | (w_m_crl & w_m_mt));

endmodule

// File: rtl/cr_unit.sv
// cr_unit: architected Condition Register with branch-condition evaluation.
//   clk, rst_n            clock, synchronous active-low reset
//   alu_*, cmp_*, xer_so  field writes from ALU record forms and compares
//   crl_*                 CR-logical ops
//   mtcrf_*               move-to-CR-fields
//   br_req/br_bo/br_bi    branch condition request (BO[0]=MSB of br_bo)
//   br_valid, br_cond_ok  registered branch result, one cycle after br_req
//   wr_conflict           registered overlap flag for same-cycle writes
//   cr_out                registered architected CR
module cr_unit
  import cr_unit_pkg::*;
#(
  parameter int                    ARCH_WIDTH = 32,
  parameter logic [ARCH_WIDTH-1:0] CR_RESET   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_wr_en,
  input  logic [2:0]            alu_d,
  input  logic                  cmp_wr_en,
  input  logic [2:0]            cmp_crf,
  input  logic [2:0]            cmp_d,
  input  logic                  xer_so,
  input  logic                  crl_en,
  input  logic [2:0]            crl_op,
  input  logic [4:0]            crl_bt,
  input  logic [4:0]            crl_ba,
  input  logic [4:0]            crl_bb,
  input  logic                  mtcrf_en,
  input  logic [7:0]            mtcrf_fxm,
  input  logic [ARCH_WIDTH-1:0] mtcrf_data,
  input  logic                  br_req,
  input  logic [4:0]            br_bo,
  input  logic [4:0]            br_bi,
  output logic                  br_valid,
  output logic                  br_cond_ok,
  output logic                  wr_conflict,
  output logic [ARCH_WIDTH-1:0] cr_out
);

  logic [ARCH_WIDTH-1:0] r_cr;
  logic                  r_br_valid;
  logic                  r_br_cond_ok;
  logic                  r_wr_conflict;
  logic [ARCH_WIDTH-1:0] w_cr_next;
  logic                  w_conflict;
  logic                  w_cond;
  logic                  w_unused_bo;

  cr_merge u_merge (
    .i_cr         (r_cr),
    .i_alu_wr_en  (alu_wr_en),
    .i_alu_d      (alu_d),
    .i_cmp_wr_en  (cmp_wr_en),
    .i_cmp_crf    (cmp_crf),
    .i_cmp_d      (cmp_d),
    .i_xer_so     (xer_so),
    .i_crl_en     (crl_en),
    .i_crl_op     (crl_op),
    .i_crl_bt     (crl_bt),
    .i_crl_ba     (crl_ba),
    .i_crl_bb     (crl_bb),
    .i_mtcrf_en   (mtcrf_en),
    .i_mtcrf_fxm  (mtcrf_fxm),
    .i_mtcrf_data (mtcrf_data),
    .o_cr_next    (w_cr_next),
    .o_conflict   (w_conflict)
  );

  // BO[0] (vector bit 4) = ignore CR; else compare CR_next[bi] with BO[1].
  // Using the post-merge value gives same-cycle write bypass.
  assign w_cond = br_bo[4] | (w_cr_next[5'd31 - br_bi] == br_bo[3]);

  // CTR-related BO bits belong to the branch unit.
  assign w_unused_bo = ^br_bo[2:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cr          <= CR_RESET;
      r_br_valid    <= 1'b0;
      r_br_cond_ok  <= 1'b0;
      r_wr_conflict <= 1'b0;
    end else begin
      r_cr          <= w_cr_next;
      r_br_valid    <= br_req;
      r_wr_conflict <= w_conflict;
      if (br_req) r_br_cond_ok <= w_cond;
    end
  end

  assign cr_out      = r_cr;
  assign br_valid    = r_br_valid;
  assign br_cond_ok  = r_br_cond_ok;
  assign wr_conflict = r_wr_conflict;

endmodule

// File: tb/tb_cr_unit.sv
module tb_cr_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_wr_en;
  logic [2:0]  alu_d;
  logic        cmp_wr_en;
  logic [2:0]  cmp_crf;
  logic [2:0]  cmp_d;
  logic        xer_so;
  logic        crl_en;
  logic [2:0]  crl_op;
  logic [4:0]  crl_bt, crl_ba, crl_bb;
  logic        mtcrf_en;
  logic [7:0]  mtcrf_fxm;
  logic [31:0] mtcrf_data;
  logic        br_req;
  logic [4:0]  br_bo, br_bi;
  logic        br_valid, br_cond_ok, wr_conflict;
  logic [31:0] cr_out;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  cr_unit #(.ARCH_WIDTH(32), .CR_RESET(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wr_en(alu_wr_en), .alu_d(alu_d),
    .cmp_wr_en(cmp_wr_en), .cmp_crf(cmp_crf), .cmp_d(cmp_d),
    .xer_so(xer_so),
    .crl_en(crl_en), .crl_op(crl_op), .crl_bt(crl_bt), .crl_ba(crl_ba), .crl_bb(crl_bb),
    .mtcrf_en(mtcrf_en), .mtcrf_fxm(mtcrf_fxm), .mtcrf_data(mtcrf_data),
    .br_req(br_req), .br_bo(br_bo), .br_bi(br_bi),
    .br_valid(br_valid), .br_cond_ok(br_cond_ok), .wr_conflict(wr_conflict),
    .cr_out(cr_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    alu_wr_en = 0; alu_d = 0; cmp_wr_en = 0; cmp_crf = 0; cmp_d = 0; xer_so = 0;
    crl_en = 0; crl_op = 0; crl_bt = 0; crl_ba = 0; crl_bb = 0;
    mtcrf_en = 0; mtcrf_fxm = 0; mtcrf_data = 0;
    br_req = 0; br_bo = 0; br_bi = 0;
  endtask

  // inputs are set before the edge; outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic crl(input logic [2:0] op, input logic [4:0] bt, ba, bb);
    crl_en = 1; crl_op = op; crl_bt = bt; crl_ba = ba; crl_bb = bb;
  endtask

  task automatic mtcrf(input logic [7:0] fxm, input logic [31:0] d);
    mtcrf_en = 1; mtcrf_fxm = fxm; mtcrf_data = d;
  endtask

  task automatic br(input logic [4:0] bo, input logic [4:0] bi);
    br_req = 1; br_bo = bo; br_bi = bi;
  endtask

  initial begin
    idle();
    // reset discards a same-cycle ALU write and branch request
    rst_n = 0; alu_wr_en = 1; alu_d = 3'b111; xer_so = 1; br(5'b10000, 5'd0);
    tick();
    chk("rst_cr", cr_out, 32'h0);
    chk("rst_brv", {31'h0, br_valid}, 32'h0);
    chk("rst_brok", {31'h0, br_cond_ok}, 32'h0);
    chk("rst_conf", {31'h0, wr_conflict}, 32'h0);
    rst_n = 1;

    alu_wr_en = 1; alu_d = 3'b100; xer_so = 1; tick();
    chk("alu_wr", cr_out, 32'h9000_0000);
    chk("alu_noconf", {31'h0, wr_conflict}, 32'h0);
    cmp_wr_en = 1; cmp_crf = 3'd7; cmp_d = 3'b001; xer_so = 0; tick();
    chk("cmp_wr7", cr_out, 32'h9000_0002);

    mtcrf(8'hFF, 32'hC000_0000); tick();
    chk("mtcrf_all", cr_out, 32'hC000_0000);
    crl(3'd2, 5'd5, 5'd0, 5'd1); tick();      // crxor 1^1=0
    chk("crxor", cr_out, 32'hC000_0000);
    crl(3'd1, 5'd31, 5'd0, 5'd1); tick();     // cror -> bit31
    chk("cror", cr_out, 32'hC000_0001);
    crl(3'd3, 5'd0, 5'd0, 5'd1); tick();      // crnand 1,1 -> 0 into bit0
    chk("crnand", cr_out, 32'h4000_0001);
    crl(3'd7, 5'd2, 5'd3, 5'd3); tick();      // crorc 0|~0 -> 1 into bit2
    chk("crorc", cr_out, 32'h6000_0001);

    mtcrf(8'hFF, 32'h0); tick();
    chk("mtcrf_clr", cr_out, 32'h0);
    mtcrf(8'b1000_0001, 32'hFFFF_FFFF); tick();
    chk("mtcrf_f07", cr_out, 32'hF000_000F);
    mtcrf(8'h00, 32'hFFFF_FFFF); tick();
    chk("mtcrf_nop", cr_out, 32'hF000_000F);

    // ALU and compare both target field 0: ALU wins, conflict flagged once
    alu_wr_en = 1; alu_d = 3'b010; cmp_wr_en = 1; cmp_crf = 3'd0; cmp_d = 3'b100; xer_so = 0;
    tick();
    chk("conf_cr", cr_out, 32'h4000_000F);
    chk("conf_flag", {31'h0, wr_conflict}, 32'h1);
    tick();
    chk("conf_drop", {31'h0, wr_conflict}, 32'h0);
    chk("conf_hold", cr_out, 32'h4000_000F);

    // disjoint same-cycle writes merge without conflict
    alu_wr_en = 1; alu_d = 3'b000; cmp_wr_en = 1; cmp_crf = 3'd7; cmp_d = 3'b000; tick();
    chk("disj_cr", cr_out, 32'h0);
    chk("disj_conf", {31'h0, wr_conflict}, 32'h0);

    // branch bypass: ALU sets EQ in the same cycle as the request
    alu_wr_en = 1; alu_d = 3'b001; br(5'b01100, 5'd2); tick();
    chk("byp_brv", {31'h0, br_valid}, 32'h1);
    chk("byp_ok", {31'h0, br_cond_ok}, 32'h1);
    chk("byp_cr", cr_out, 32'h2000_0000);
    tick();
    chk("br_drop", {31'h0, br_valid}, 32'h0);
    chk("br_hold", {31'h0, br_cond_ok}, 32'h1);
    br(5'b01100, 5'd3); tick();
    chk("br_so0_t", {31'h0, br_cond_ok}, 32'h0);
    // back-to-back requests
    br(5'b10000, 5'd3); tick();
    chk("br_always_v", {31'h0, br_valid}, 32'h1);
    chk("br_always", {31'h0, br_cond_ok}, 32'h1);
    br(5'b00000, 5'd2); tick();
    chk("br_eq_f", {31'h0, br_cond_ok}, 32'h0);
    br(5'b00100, 5'd3); tick();
    chk("br_so_f", {31'h0, br_cond_ok}, 32'h1);

    // reset in the request cycle suppresses the pulse
    rst_n = 0; br(5'b10000, 5'd0); tick();
    chk("rst2_brv", {31'h0, br_valid}, 32'h0);
    chk("rst2_brok", {31'h0, br_cond_ok}, 32'h0);
    chk("rst2_cr", cr_out, 32'h0);
    rst_n = 1;

    // CR-logical reads the old CR even when ALU writes its source bit
    alu_wr_en = 1; alu_d = 3'b100; crl(3'd1, 5'd31, 5'd0, 5'd0); tick();
    chk("crl_old_src", cr_out, 32'h8000_0000);
    // crl targets bit 1 inside ALU field: ALU wins, conflict raised
    alu_wr_en = 1; alu_d = 3'b000; crl(3'd4, 5'd1, 5'd31, 5'd31); tick();
    chk("crl_alu_cr", cr_out, 32'h0);
    chk("crl_alu_conf", {31'h0, wr_conflict}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/cr_unit.md
# cr_unit

Architected Condition Register (CR) for the 32-bit PowerPC core: the consumer of the ALU's CR0 result bus and the compare ALU's CRX result bus. It holds CR[0:31] (eight 4-bit fields, LT/GT/EQ/SO), applies field writes from ALU record forms, compares, CR-logical ops and mtcrf, and evaluates the CR half of conditional-branch conditions for the branch unit with a one-cycle registered result.

## Interface
- ARCH_WIDTH, 32: CR width; big-endian bit numbering, bit 0 = MSB.
- CR_RESET, 32'h0: CR value loaded on reset.

Clocking: one clock, `clk`; reset `rst_n` is synchronous and active-low.

- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- alu_wr_en  in  1  write CR0 from the ALU record form.
- alu_d  in  3  {LT,GT,EQ} from the ALU.
- cmp_wr_en  in  1  write field cmp_crf from the compare ALU.
- cmp_crf  in  3  target field index 0..7.
- cmp_d  in  3  {LT,GT,EQ} from the compare ALU.
- xer_so  in  1  current XER[SO]; copied into the SO bit of every ALU/compare field write.
- crl_en  in  1  CR-logical op valid.
- crl_op  in  3  0 crand, 1 cror, 2 crxor, 3 crnand, 4 crnor, 5 creqv, 6 crandc, 7 crorc.
- crl_bt, crl_ba, crl_bb  in  5 each  target and source bit indices.
- mtcrf_en  in  1  move-to-CR-fields valid.
- mtcrf_fxm  in  8  field mask; fxm[i] selects field i.
- mtcrf_data  in  32  source GPR value.
- br_req  in  1  branch-condition evaluation request.
- br_bo  in  5  BO field.
- br_bi  in  5  BI bit index.
- br_valid  out  1  pulses one cycle after br_req.
- br_cond_ok  out  1  CR condition satisfied; meaningful only while br_valid=1.
- wr_conflict  out  1  pulses one cycle after overlapping same-cycle writes.
- cr_out  out  32  registered architected CR.

## Operation
- Field n occupies bits 4n..4n+3 = LT,GT,EQ,SO.
- ALU write: CR[0:3] <= {alu_d, xer_so}. Compare write: field cmp_crf <= {cmp_d, xer_so}.
- CR-logical: CR[bt] <= op(CR[ba], CR[bb]). Sources are read from the current register, never from same-cycle writes. Only bit bt changes.
- mtcrf: for each i with fxm[i]=1, field i <= mtcrf_data field i. fxm=0 is a no-op.
- Same-cycle writes merge per bit. Priority is alu > cmp > crl > mtcrf. Bits not written by any source hold their value.
- wr_conflict is registered. It is 1 the cycle after any bit was targeted by two or more sources in the same cycle. The merge still completes normally.
- Branch evaluation uses CR_next, the post-merge value including same-cycle writes (bypass):
  - if br_bo[0]=1, cond_ok=1;
  - otherwise cond_ok = (CR_next[br_bi] == br_bo[1]).
  - br_bo[2:4] (CTR handling) is ignored by this block.

## Timing
- Reset, while rst_n=0 at a clock edge: cr_out=CR_RESET, br_valid=0, br_cond_ok=0, wr_conflict=0. All requests presented in that cycle are discarded.
- Write latency: cr_out reflects a write in cycle t at cycle t+1.
- Branch latency: br_req at t gives br_valid=1 and br_cond_ok at t+1.
- br_req may be asserted every cycle; no stall and no backpressure.
- br_cond_ok holds its last value while br_valid=0.
- All inputs are sampled only while their enable is high.
- A branch in the same cycle as a write to bit bi sees the written value.
- Reset asserted between br_req and br_valid suppresses the pulse.

## Structure
- ctrl_encode_def.v gains the `CRLOp_*` encodings and `CRLOp_WIDTH`.
- arch_def.v gains `CR_WIDTH`, `CRF_WIDTH` and the field bit offsets (`CR_LT`=0, `CR_GT`=1, `CR_EQ`=2, `CR_SO`=3).
- One sub-module, cr_merge, is combinational. It takes the current CR and the four write requests and produces CR_next plus a conflict flag. The top level holds the CR, branch and conflict registers.

## Test plan
- Reset: drive rst_n=0 with alu_wr_en=1 -> cr_out=0, br_valid=0 and wr_conflict=0 the next cycle.
- ALU write with alu_d=3'b100, xer_so=1 -> cr_out=32'h9000_0000. Then cmp_wr_en, cmp_crf=7, cmp_d=3'b001, xer_so=0 -> cr_out=32'h9000_0002.
- CR-logical: from CR=32'hC000_0000, crl_op=crxor, bt=5, ba=0, bb=1 -> bit5=0, CR unchanged. Then crl_op=cror, bt=31 -> cr_out=32'hC000_0001.
- mtcrf: mtcrf_fxm=8'b1000_0001, data=32'hFFFF_FFFF on CR=0 -> cr_out=32'hF000_000F.
- Conflict: alu_wr_en plus cmp_wr_en with cmp_crf=0, alu_d=3'b010, cmp_d=3'b100, xer_so=0 -> CR[0:3]=4'b0100, wr_conflict=1 for one cycle.
- Bypass: CR=0, same cycle ALU write EQ=1 (alu_d=3'b001) and br_req with bo=5'b01100, bi=2 -> next cycle br_valid=1, br_cond_ok=1. bo=5'b10000 -> br_cond_ok=1 regardless of CR.
